usb_tx_arbiter: RTL and testbench

USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

---
 rtl/usb_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_usb_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: picks ACK/NACK/hash-response packets and feeds them
// byte by byte to a USB transmitter, with a watchdog on each packet.
`timescale 1ns/1ps
module usb_tx_arbiter #(
  parameter logic [7:0] ACK_PID    = 8'hD2,
  parameter logic [7:0] NACK_PID   = 8'h5A,
  parameter logic [7:0] DATA_PID   = 8'hC3,
  parameter int         RESP_BYTES = 36,
  parameter int         TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    req_ack,
  input  logic                    req_nack,
  input  logic                    req_hash,
  input  logic [8*RESP_BYTES-1:0] hash_data,
  input  logic                    read_enable,
  input  logic                    tx_done,
  output logic                    transmit_start,
  output logic [7:0]              tx_byte,
  output logic                    transmit_empty,
  output logic                    busy,
  output logic [1:0]              grant,
  output logic                    req_dropped,
  output logic                    tx_timeout
);
  localparam int IW = $clog2(RESP_BYTES + 2);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LEN_HS = IW'(RESP_BYTES + 1);
  localparam logic [IW-1:0] LEN_HK = IW'(1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, START, SEND, WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic pend_ack, pend_nack, pend_hash;
  logic ack_eff, nack_eff, hash_eff;
  logic go, abort, consume;
  logic [1:0] grant_sel;
  logic [7:0] pid_sel;
  logic [IW-1:0] idx, len;
  logic [WW-1:0] wd;
  logic [8*RESP_BYTES-1:0] snap;

  assign ack_eff  = pend_ack | req_ack;
  assign nack_eff = pend_nack | req_nack;
  assign hash_eff = pend_hash | req_hash;

  assign go      = (state == IDLE) & (ack_eff | nack_eff | hash_eff);
  assign abort   = (state != IDLE) & (wd == WD_MAX);
  assign len     = (grant == 2'b11) ? LEN_HS : LEN_HK;
  assign consume = (state == SEND) & read_enable & (idx != len);

  always_comb begin
    grant_sel = 2'b11;
    pid_sel   = DATA_PID;
    if (nack_eff) begin
      grant_sel = 2'b10;
      pid_sel   = NACK_PID;
    end else if (ack_eff) begin
      grant_sel = 2'b01;
      pid_sel   = ACK_PID;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (go) state_nxt = START;
      START:     state_nxt = SEND;
      SEND:      if (idx == len) state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    transmit_start = (state == START);
    busy           = (state != IDLE);
    transmit_empty = (state == IDLE) | (idx == len);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_ack    <= 1'b0;
      pend_nack   <= 1'b0;
      pend_hash   <= 1'b0;
      req_dropped <= 1'b0;
      tx_timeout  <= 1'b0;
      grant       <= 2'b00;
      snap        <= '0;
      idx         <= '0;
      tx_byte     <= 8'h00;
      wd          <= '0;
    end else begin
      // a granted ACK and an ACK losing to NACK both leave no flag
      pend_ack    <= ack_eff & ~go;
      pend_nack   <= nack_eff & ~go;
      pend_hash   <= hash_eff & ~(go & (grant_sel == 2'b11));
      req_dropped <= go & ack_eff & nack_eff;
      tx_timeout  <= abort;
      if (go)
        grant <= grant_sel;
      else if (state != IDLE && state_nxt == IDLE)
        grant <= 2'b00;
      if (go && grant_sel == 2'b11)
        snap <= hash_data;
      if (go) begin
        idx     <= '0;
        tx_byte <= pid_sel;
      end else if (consume) begin
        idx <= idx + 1'b1;
        if (idx != len - 1'b1)
          tx_byte <= snap[8*idx +: 8];
      end
      if (go || abort)
        wd <= '0;
      else if (state != IDLE)
        wd <= wd + 1'b1;
    end
  end
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: vector table, directed corner sequences and
// a randomized run against a packet-level reference model.
`timescale 1ns/1ps
module tb_usb_tx_arbiter;
  localparam int RB = 36;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic req_ack = 1'b0, req_nack = 1'b0, req_hash = 1'b0;
  logic read_enable = 1'b0, tx_done = 1'b0;
  logic [8*RB-1:0] hash_data = '0;
  logic transmit_start, transmit_empty, busy;
  logic req_dropped, tx_timeout;
  logic [7:0] tx_byte;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;

  usb_tx_arbiter dut (
    .clk(clk), .n_rst(n_rst),
    .req_ack(req_ack), .req_nack(req_nack), .req_hash(req_hash),
    .hash_data(hash_data),
    .read_enable(read_enable), .tx_done(tx_done),
    .transmit_start(transmit_start), .tx_byte(tx_byte),
    .transmit_empty(transmit_empty), .busy(busy), .grant(grant),
    .req_dropped(req_dropped), .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic ra, rn, rh, re, td;
    logic [6:0] st;
    logic cb;
    logic [7:0] b;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  // {start, busy, grant, empty, dropped, timeout}
  function automatic logic [6:0] st();
    return {transmit_start, busy, grant, transmit_empty,
            req_dropped, tx_timeout};
  endfunction

  task automatic finish_pkt(input int n);
    tick();
    for (int i = 0; i < n; i++) begin
      read_enable = 1'b1;
      tick();
      read_enable = 1'b0;
    end
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  logic [7:0] q [$];
  bit m_busy, m_start, m_drop, pa, pn, ph;
  logic [1:0] m_grant;
  int age;
  bit ra, rn, rh, re, td, a, n, h;
  bit tout_seen, bad;

  initial begin
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 7'b1101000, 1'b1, 8'hD2};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 7'b0101000, 1'b1, 8'hD2};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 7'b0101100, 1'b0, 8'h00};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 7'b0101100, 1'b0, 8'h00};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 7'b0000100, 1'b0, 8'h00};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 7'b1110010, 1'b1, 8'h5A};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 7'b0110000, 1'b1, 8'h5A};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 7'b0110100, 1'b0, 8'h00};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 7'b0110100, 1'b0, 8'h00};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 7'b0000100, 1'b0, 8'h00};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 7'b0000100, 1'b0, 8'h00};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 7'b0000100, 1'b0, 8'h00};

    #1;
    check("reset_status", st(), 7'b0000100);
    check("reset_byte", tx_byte, 8'h00);
    tick();
    tick();
    n_rst = 1'b1;

    // ACK only, then ACK/NACK collision
    for (int i = 0; i < 12; i++) begin
      req_ack = tbl[i].ra; req_nack = tbl[i].rn; req_hash = tbl[i].rh;
      read_enable = tbl[i].re; tx_done = tbl[i].td;
      tick();
      req_ack = 1'b0; req_nack = 1'b0; req_hash = 1'b0;
      read_enable = 1'b0; tx_done = 1'b0;
      check($sformatf("vec%0d_status", i), st(), tbl[i].st);
      if (tbl[i].cb) check($sformatf("vec%0d_byte", i), tx_byte, tbl[i].b);
    end

    // hash response, payload altered mid-packet
    for (int k = 0; k < RB; k++) hash_data[8*k +: 8] = 8'(k);
    req_hash = 1'b1;
    tick();
    req_hash = 1'b0;
    check("hash_start", st(), 7'b1111000);
    check("hash_pid", tx_byte, 8'hC3);
    tick();
    for (int k = 0; k < RB + 1; k++) begin
      check($sformatf("hash_byte%0d", k), tx_byte,
            (k == 0) ? 8'hC3 : 8'(k - 1));
      if (k == 5) hash_data = ~hash_data;
      read_enable = 1'b1;
      tick();
      read_enable = 1'b0;
      if (k < RB) check($sformatf("hash_empty%0d", k), transmit_empty, 1'b0);
    end
    check("hash_done_empty", {busy, transmit_empty}, 2'b11);
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("hash_idle", st(), 7'b0000100);

    // queueing: hash and NACK raised during an ACK packet
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    tick();
    req_hash = 1'b1;
    tick();
    req_hash = 1'b0;
    req_nack = 1'b1;
    tick();
    req_nack = 1'b0;
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("queue_idle_gap", st(), 7'b0000100);
    tick();
    check("queue_nack_start", st(), 7'b1110000);
    check("queue_nack_pid", tx_byte, 8'h5A);
    finish_pkt(1);
    check("queue_idle_gap2", st(), 7'b0000100);
    tick();
    check("queue_hash_start", st(), 7'b1111000);
    check("queue_hash_pid", tx_byte, 8'hC3);
    finish_pkt(RB + 1);

    // watchdog: tx_done withheld
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    check("to_ack_start", st(), 7'b1101000);
    tout_seen = 1'b0;
    for (int c = 1; c <= 1100 && !tout_seen; c++) begin
      req_hash = (c == 50);
      read_enable = (c == 3);
      tick();
      if (tx_timeout) begin
        tout_seen = 1'b1;
        check("to_cycle", c, 1024);
        check("to_status", st(), 7'b0000101);
      end
    end
    req_hash = 1'b0;
    read_enable = 1'b0;
    if (!tout_seen) check("to_seen", 1'b0, 1'b1);
    tick();
    check("to_hash_start", st(), 7'b1111000);
    finish_pkt(RB + 1);

    // reset at byte 10 of a hash packet, NACK pending
    req_hash = 1'b1;
    tick();
    req_hash = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      read_enable = 1'b1;
      req_nack = (i == 3);
      tick();
    end
    read_enable = 1'b0;
    req_nack = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("midrst_status", st(), 7'b0000100);
    check("midrst_byte", tx_byte, 8'h00);
    tick();
    n_rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (transmit_start || busy) bad = 1'b1;
    end
    check("midrst_quiet", bad, 1'b0);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    check("midrst_new_req", st(), 7'b1101000);

    // randomized run against packet-level model
    n_rst = 1'b0;
    #1;
    tick();
    n_rst = 1'b1;
    q.delete();
    m_busy = 0; m_start = 0; m_drop = 0;
    pa = 0; pn = 0; ph = 0;
    m_grant = 2'b00;
    age = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ra = ($urandom_range(0, 19) == 0);
      rn = ($urandom_range(0, 19) == 0);
      rh = ($urandom_range(0, 19) == 0);
      re = ($urandom_range(0, 1) == 1);
      td = 1'b0;
      if (!m_busy || q.size() != 0) td = ($urandom_range(0, 9) == 0);
      else if (age >= 2) td = ($urandom_range(0, 2) == 0);
      for (int w = 0; w < RB / 4; w++) hash_data[32*w +: 32] = $urandom();
      req_ack = ra; req_nack = rn; req_hash = rh;
      read_enable = re; tx_done = td;

      m_drop = 1'b0;
      if (!m_busy) begin
        a = pa | ra; n = pn | rn; h = ph | rh;
        m_start = 1'b0;
        if (a || n || h) begin
          m_drop = a && n;
          q.delete();
          if (n) begin
            m_grant = 2'b10; q.push_back(8'h5A);
          end else if (a) begin
            m_grant = 2'b01; q.push_back(8'hD2);
          end else begin
            m_grant = 2'b11; q.push_back(8'hC3);
            for (int k = 0; k < RB; k++) q.push_back(hash_data[8*k +: 8]);
          end
          pa = 1'b0;
          pn = 1'b0;
          ph = h && (m_grant != 2'b11);
          m_busy = 1'b1;
          m_start = 1'b1;
          age = 0;
        end
      end else begin
        pa |= ra; pn |= rn; ph |= rh;
        if (!m_start && re && q.size() != 0) void'(q.pop_front());
        else if (td && q.size() == 0 && age >= 2) begin
          m_busy = 1'b0;
          m_grant = 2'b00;
        end
        m_start = 1'b0;
      end

      tick();
      if (m_busy && q.size() == 0) age++;
      check($sformatf("rand%0d_status", cyc), st(),
            {m_start, m_busy, m_grant, (!m_busy || q.size() == 0),
             m_drop, 1'b0});
      if (q.size() != 0) check($sformatf("rand%0d_byte", cyc), tx_byte, q[0]);
    end
    req_ack = 1'b0; req_nack = 1'b0; req_hash = 1'b0;
    read_enable = 1'b0; tx_done = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
